mole_round_ctrl: RTL and testbench

//  Game-round controller for the whack-a-mole datapath. Samples the one-hot

---
 rtl/mole_round_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mole_round_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: gap -> mole up -> hit/timeout, with score, misses and game over.
// Optional feature macro SPEEDUP_EN: each hit shortens the up window down to MIN_UP_TICKS.
module mole_round_ctrl #(
    parameter int unsigned UP_TICKS     = 750,
    parameter int unsigned GAP_TICKS    = 250,
    parameter int unsigned MAX_MISSES   = 3,
    parameter int unsigned MIN_UP_TICKS = 250,
    parameter int unsigned SPEEDUP_STEP = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start,
    input  logic [15:0] whack,
    input  logic [15:0] mole_location,
    output logic [15:0] mole_onehot,
    output logic [7:0]  score,
    output logic [3:0]  misses,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic        game_over
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GAP  = 2'd1;
    localparam logic [1:0] ST_UP   = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    localparam logic [15:0] GAP_LAST   = 16'(GAP_TICKS - 1);
    localparam logic [3:0]  MISS_LIMIT = 4'(MAX_MISSES);

    logic [1:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] mole_q, mole_d;
    logic [15:0] last_loc_q, last_loc_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  misses_q, misses_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;
    logic        game_over_q, game_over_d;

    logic        gameStart;
    logic        hitEvent;
    logic        candOneHot;
    logic [15:0] candPick;
    logic [15:0] upLen;
    logic [15:0] upLast;

    assign gameStart = start && ((state_q == ST_IDLE) || (state_q == ST_OVER));
    assign hitEvent  = (state_q == ST_UP) && (|(whack & mole_q));
    assign upLast    = upLen - 16'd1;

`ifdef SPEEDUP_EN
    logic [15:0] up_len_q, up_len_d;
    logic [15:0] upLenShort;

    // Shrink by one step, clamped at the floor so the subtraction can never wrap.
    always_comb begin
        upLenShort = 16'(MIN_UP_TICKS);
        if ({1'b0, up_len_q} >= (17'(MIN_UP_TICKS) + 17'(SPEEDUP_STEP))) begin
            upLenShort = up_len_q - 16'(SPEEDUP_STEP);
        end
    end

    always_comb begin
        up_len_d = up_len_q;
        if (gameStart) begin
            up_len_d = 16'(UP_TICKS);
        end else if (hitEvent) begin
            up_len_d = upLenShort;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            up_len_q <= 16'(UP_TICKS);
        end else begin
            up_len_q <= up_len_d;
        end
    end

    assign upLen = up_len_q;
`else
    assign upLen = 16'(UP_TICKS);
`endif

    assign candOneHot = (mole_location != 16'd0) &&
                        ((mole_location & (mole_location - 16'd1)) == 16'd0);

    // A zero candidate falls back to hole 0; a rotated non-zero value stays non-zero.
    always_comb begin
        candPick = mole_location;
        if (mole_location == 16'd0) begin
            candPick = 16'h0001;
        end else if (!candOneHot || (mole_location == last_loc_q)) begin
            candPick = {mole_location[14:0], mole_location[15]};
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        mole_d       = mole_q;
        last_loc_d   = last_loc_q;
        score_d      = score_q;
        misses_d     = misses_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        game_over_d  = game_over_q;

        case (state_q)
            ST_IDLE: begin
                mole_d = 16'd0;
                if (gameStart) begin
                    score_d  = 8'd0;
                    misses_d = 4'd0;
                    timer_d  = 16'd0;
                    state_d  = ST_GAP;
                end
            end

            ST_GAP: begin
                mole_d = 16'd0;
                if (tick) begin
                    if (timer_q == GAP_LAST) begin
                        mole_d     = candPick;
                        last_loc_d = candPick;
                        timer_d    = 16'd0;
                        state_d    = ST_UP;
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
            end

            // A hit on the timeout edge takes priority over the miss.
            ST_UP: begin
                if (hitEvent) begin
                    if (score_q != 8'hFF) begin
                        score_d = score_q + 8'd1;
                    end
                    hit_pulse_d = 1'b1;
                    mole_d      = 16'd0;
                    timer_d     = 16'd0;
                    state_d     = ST_GAP;
                end else if (tick) begin
                    if (timer_q == upLast) begin
                        misses_d     = misses_q + 4'd1;
                        miss_pulse_d = 1'b1;
                        mole_d       = 16'd0;
                        timer_d      = 16'd0;
                        if ((misses_q + 4'd1) == MISS_LIMIT) begin
                            game_over_d = 1'b1;
                            state_d     = ST_OVER;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end
                end
            end

            ST_OVER: begin
                mole_d = 16'd0;
                if (gameStart) begin
                    game_over_d = 1'b0;
                    score_d     = 8'd0;
                    misses_d    = 4'd0;
                    timer_d     = 16'd0;
                    state_d     = ST_GAP;
                end
            end

            default: begin
                mole_d  = 16'd0;
                timer_d = 16'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= 16'd0;
            mole_q       <= 16'd0;
            last_loc_q   <= 16'd0;
            score_q      <= 8'd0;
            misses_q     <= 4'd0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            mole_q       <= mole_d;
            last_loc_q   <= last_loc_d;
            score_q      <= score_d;
            misses_q     <= misses_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            game_over_q  <= game_over_d;
        end
    end

    assign mole_onehot = mole_q;
    assign score       = score_q;
    assign misses      = misses_q;
    assign hit_pulse   = hit_pulse_q;
    assign miss_pulse  = miss_pulse_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed testbench for mole_round_ctrl (UP_TICKS=4, GAP_TICKS=2, MAX_MISSES=3).
// With SPEEDUP_EN defined a second instance checks the shrinking up window.
module tb_mole_round_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        start;
    logic [15:0] whack;
    logic [15:0] moleLocation;
    logic [15:0] moleOnehot;
    logic [7:0]  score;
    logic [3:0]  misses;
    logic        hitPulse;
    logic        missPulse;
    logic        gameOver;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    mole_round_ctrl #(
        .UP_TICKS    (4),
        .GAP_TICKS   (2),
        .MAX_MISSES  (3),
        .MIN_UP_TICKS(4),
        .SPEEDUP_STEP(1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .start        (start),
        .whack        (whack),
        .mole_location(moleLocation),
        .mole_onehot  (moleOnehot),
        .score        (score),
        .misses       (misses),
        .hit_pulse    (hitPulse),
        .miss_pulse   (missPulse),
        .game_over    (gameOver)
    );

`ifdef SPEEDUP_EN
    logic [15:0] moleOnehot2;
    logic [7:0]  score2;
    logic [3:0]  misses2;
    logic        hitPulse2;
    logic        missPulse2;
    logic        gameOver2;

    mole_round_ctrl #(
        .UP_TICKS    (8),
        .GAP_TICKS   (2),
        .MAX_MISSES  (15),
        .MIN_UP_TICKS(4),
        .SPEEDUP_STEP(2)
    ) dutSpeed (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .start        (start),
        .whack        (whack),
        .mole_location(moleLocation),
        .mole_onehot  (moleOnehot2),
        .score        (score2),
        .misses       (misses2),
        .hit_pulse    (hitPulse2),
        .miss_pulse   (missPulse2),
        .game_over    (gameOver2)
    );
`endif

    // Advance by whole clocks; inputs change and outputs are sampled 1ns after each edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

`ifdef SPEEDUP_EN
    task automatic measureWindow(input string tag, input int expected);
        int n;
        applyStimulus(2);
        checkOutput({tag, " raised"}, 32'(moleOnehot2 != 16'd0), 32'd1);
        n = 0;
        while (moleOnehot2 != 16'd0 && n < 20) begin
            applyStimulus(1);
            n++;
        end
        checkOutput({tag, " window"}, 32'(n), 32'(expected));
    endtask

    task automatic hitNextMole();
        applyStimulus(2);
        whack = 16'hFFFF;
        applyStimulus(1);
        whack = 16'h0000;
        checkOutput("speed hit", 32'(hitPulse2), 32'd1);
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        tick         = 1'b1;
        start        = 1'b0;
        whack        = 16'h0000;
        moleLocation = 16'h0000;
        applyStimulus(2);
        checkOutput("reset mole", 32'(moleOnehot), 32'h0);
        checkOutput("reset score", 32'(score), 32'h0);
        checkOutput("reset misses", 32'(misses), 32'h0);
        checkOutput("reset pulses", 32'({hitPulse, missPulse}), 32'h0);
        checkOutput("reset over", 32'(gameOver), 32'h0);
        rst_n = 1'b1;

        // Reach UP, then reset mid-game with start held high
        moleLocation = 16'h0010;
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(2);
        checkOutput("first mole", 32'(moleOnehot), 32'h0010);
        rst_n = 1'b0;
        start = 1'b1;
        applyStimulus(1);
        checkOutput("midgame reset mole", 32'(moleOnehot), 32'h0);
        checkOutput("midgame reset over", 32'(gameOver), 32'h0);
        rst_n = 1'b1;
        start = 1'b0;
        applyStimulus(5);
        checkOutput("idle no mole", 32'(moleOnehot), 32'h0);

        // Start, hit the first mole
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        applyStimulus(1);
        checkOutput("gap blank", 32'(moleOnehot), 32'h0);
        applyStimulus(1);
        checkOutput("mole after gap", 32'(moleOnehot), 32'h0010);
        whack = 16'h0010;
        applyStimulus(1);
        whack = 16'h0000;
        checkOutput("hit pulse", 32'(hitPulse), 32'd1);
        checkOutput("hit score", 32'(score), 32'd1);
        checkOutput("hit clears mole", 32'(moleOnehot), 32'h0);
        checkOutput("hit no miss", 32'(missPulse), 32'd0);
        applyStimulus(1);
        checkOutput("hit pulse one clk", 32'(hitPulse), 32'd0);
        applyStimulus(1);
        checkOutput("repeat rotates", 32'(moleOnehot), 32'h0020);

        // Three timeouts end the game
        applyStimulus(3);
        checkOutput("mole still up", 32'(moleOnehot), 32'h0020);
        checkOutput("no miss yet", 32'(misses), 32'd0);
        applyStimulus(1);
        checkOutput("miss1 pulse", 32'(missPulse), 32'd1);
        checkOutput("miss1 count", 32'(misses), 32'd1);
        checkOutput("miss1 mole clear", 32'(moleOnehot), 32'h0);
        checkOutput("miss1 not over", 32'(gameOver), 32'd0);
        moleLocation = 16'h8000;
        applyStimulus(2);
        checkOutput("mole 8000", 32'(moleOnehot), 32'h8000);
        applyStimulus(4);
        checkOutput("miss2 count", 32'(misses), 32'd2);
        applyStimulus(2);
        checkOutput("8000 wraps", 32'(moleOnehot), 32'h0001);
        moleLocation = 16'h0000;
        applyStimulus(4);
        checkOutput("miss3 count", 32'(misses), 32'd3);
        checkOutput("miss3 pulse", 32'(missPulse), 32'd1);
        checkOutput("game over", 32'(gameOver), 32'd1);
        applyStimulus(5);
        checkOutput("over holds", 32'(gameOver), 32'd1);
        checkOutput("over score held", 32'(score), 32'd1);
        checkOutput("over misses held", 32'(misses), 32'd3);
        checkOutput("over no mole", 32'(moleOnehot), 32'h0);

        // Restart from OVER; zero candidate maps to hole 0
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("restart over", 32'(gameOver), 32'd0);
        checkOutput("restart score", 32'(score), 32'd0);
        checkOutput("restart misses", 32'(misses), 32'd0);
        applyStimulus(2);
        checkOutput("zero loc", 32'(moleOnehot), 32'h0001);

        // Wrong button ignored; hit on the timeout edge wins
        moleLocation = 16'h0010;
        applyStimulus(4);
        checkOutput("miss before wrong", 32'(misses), 32'd1);
        applyStimulus(2);
        checkOutput("mole 0010", 32'(moleOnehot), 32'h0010);
        whack = 16'h0001;
        applyStimulus(1);
        whack = 16'h0000;
        checkOutput("wrong whack score", 32'(score), 32'd0);
        checkOutput("wrong whack pulse", 32'(hitPulse), 32'd0);
        checkOutput("wrong whack mole", 32'(moleOnehot), 32'h0010);
        applyStimulus(2);
        whack = 16'h0010;
        applyStimulus(1);
        whack = 16'h0000;
        checkOutput("tie hit pulse", 32'(hitPulse), 32'd1);
        checkOutput("tie no miss pulse", 32'(missPulse), 32'd0);
        checkOutput("tie score", 32'(score), 32'd1);
        checkOutput("tie misses", 32'(misses), 32'd1);

        // Non-one-hot candidate rotates; timer only moves on tick
        moleLocation = 16'h0003;
        applyStimulus(2);
        checkOutput("non-onehot rot", 32'(moleOnehot), 32'h0006);
        tick = 1'b0;
        applyStimulus(10);
        checkOutput("no tick mole", 32'(moleOnehot), 32'h0006);
        checkOutput("no tick misses", 32'(misses), 32'd1);
        tick = 1'b1;
        applyStimulus(3);
        checkOutput("tick resumes mole", 32'(moleOnehot), 32'h0006);
        applyStimulus(1);
        checkOutput("tick timeout", 32'(misses), 32'd2);
        checkOutput("tick timeout pulse", 32'(missPulse), 32'd1);

`ifdef SPEEDUP_EN
        rst_n = 1'b0;
        applyStimulus(1);
        rst_n = 1'b1;
        moleLocation = 16'h0010;
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        measureWindow("speed 0 hits", 8);
        hitNextMole();
        measureWindow("speed 1 hit", 6);
        hitNextMole();
        measureWindow("speed 2 hits", 4);
        hitNextMole();
        measureWindow("speed 3 hits", 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
